// File: rtl/loop_nest_up.sv
// Up-counting N-level loop-index generator with valid/ready output stream.
// Level 0 is innermost; per-level first/last flags are registered with the counts.
module loop_nest_up #(
    parameter int unsigned N = 3,
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [N*W-1:0] cfg_max,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [N*W-1:0] m_count,
    output logic [N-1:0]   m_first,
    output logic [N-1:0]   m_last,
    output logic           m_last_all,
    output logic           done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t         state_q, state_d;
    logic [N*W-1:0] max_q, max_d;
    logic [N*W-1:0] count_q, count_d;
    logic [N-1:0]   first_q, first_d;
    logic [N-1:0]   last_q, last_d;
    logic           last_all_q, last_all_d;
    logic           done_q, done_d;

    logic           inner_at_max;
    logic [W-1:0]   cur, nxt, mx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            max_q      <= '0;
            count_q    <= '0;
            first_q    <= '1;
            last_q     <= '0;
            last_all_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            max_q      <= max_d;
            count_q    <= count_d;
            first_q    <= first_d;
            last_q     <= last_d;
            last_all_q <= last_all_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        max_d        = max_q;
        count_d      = count_q;
        first_d      = first_q;
        last_d       = last_q;
        last_all_d   = last_all_q;
        done_d       = 1'b0;
        inner_at_max = 1'b1;
        cur          = '0;
        nxt          = '0;
        mx           = '0;
        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    state_d = RUN;
                    max_d   = cfg_max;
                    count_d = '0;
                    first_d = '1;
                    for (int unsigned i = 0; i < N; i++) begin
                        last_d[i] = (cfg_max[i*W +: W] == '0);
                    end
                    last_all_d = &last_d;
                end
            end
            RUN: begin
                if (m_ready) begin
                    if (last_all_q) begin
                        state_d    = IDLE;
                        count_d    = '0;
                        first_d    = '1;
                        last_d     = '0;
                        last_all_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        // Ripple carry: a level moves only when every inner level sits at its max.
                        for (int unsigned i = 0; i < N; i++) begin
                            cur = count_q[i*W +: W];
                            mx  = max_q[i*W +: W];
                            if (inner_at_max) begin
                                nxt = (cur == mx) ? '0 : cur + 1'b1;
                            end else begin
                                nxt = cur;
                            end
                            count_d[i*W +: W] = nxt;
                            first_d[i]        = (nxt == '0);
                            last_d[i]         = (nxt == mx);
                            inner_at_max      = inner_at_max & (cur == mx);
                        end
                        last_all_d = &last_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready  = (state_q == IDLE);
        m_valid    = (state_q == RUN);
        m_count    = count_q;
        m_first    = first_q;
        m_last     = last_q;
        m_last_all = last_all_q;
        done       = done_q;
    end

endmodule

// File: doc/loop_nest_up.md
# loop_nest_up

Up-counting, multi-level loop-index generator with a valid/ready output stream. It is the ascending counterpart of the team's descending load/enable `counter`: that block consumes an iteration budget and reports `last`, while this block produces ordered index tuples from 0 up to a configured maximum. It sits in the address-generation path, where it feeds memory-address and tile-offset logic. Every index tuple carries per-level first/last flags.

## Interface
- N, default 3: number of loop levels; level 0 is innermost.
- W, default 8: width of each level index and maximum.
- clk  in  1  clock; every flop is rising-edge.
- rst  in  1  synchronous active-high reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  block accepts configuration (high only in IDLE).
- cfg_max  in  N×W  inclusive maximum per level; level i counts 0..cfg_max[i].
- m_valid  out  1  index tuple valid.
- m_ready  in  1  downstream accepts tuple.
- m_count  out  N×W  current index per level.
- m_first  out  N  m_first[i] = (m_count[i] == 0).
- m_last  out  N  m_last[i] = (m_count[i] == max[i]).
- m_last_all  out  1  AND of all m_last bits; marks the final tuple of the sequence.
- done  out  1  one-cycle pulse after the final tuple is accepted.

## Operation
- States: IDLE and RUN.
- IDLE:
  - cfg_ready=1, m_valid=0.
  - On cfg_valid, latch cfg_max into internal max[], clear all counts, and go to RUN.
- RUN:
  - cfg_ready=0, m_valid=1. cfg_max is ignored.
- Beat: a beat is m_valid && m_ready. On each beat:
  - Level 0 increments.
  - Level i wraps to 0 when it is at max[i] and all inner levels j<i are at max[j].
  - Level i increments when all inner levels are at max but level i itself is not.
  - Otherwise level i holds.
- Final beat: a beat with m_last_all=1 returns the block to IDLE, leaves counts at 0, and pulses done.
- Sequence length: total beats per configuration = product over i of (max[i]+1). Order is lexicographic, with the outer level most significant.
- Widths: the increment is count+1 in W bits. Because count ≤ max always holds, no overflow occurs. max = 2^W−1 is legal.
- Zero-max level: a level with max=0 holds m_first[i]=m_last[i]=1 on every beat. If all levels have max=0, the sequence is a single beat.
- Flag generation: m_first, m_last and m_last_all are registered alongside m_count, with no combinational path from m_ready. They are recomputed from the next-count value.
- Stall: while m_valid && !m_ready, m_count, m_first, m_last and m_last_all hold stable.
- Reset: rst dominates every other input, mid-sequence included. State goes to IDLE; m_count=0, m_first=all-ones, m_last=0, m_last_all=0, done=0, m_valid=0, cfg_ready=1 (after the reset edge). max[] clears to 0.

## Timing
- Configuration latency: a cfg handshake at edge t gives m_valid=1 from cycle t+1, with m_count=0, m_first=all-ones, and m_last[i]=(max[i]==0).
- Throughput: one tuple per cycle while m_ready=1.
- End of sequence: the final beat at edge t gives done=1 and m_valid=0 during cycle t+1. cfg_ready=1 in cycle t+1.
- Back-to-back configurations: the next configuration is accepted no earlier than edge t+1. This is exactly one bubble between sequences.
- done width: done is high for exactly one cycle and is never asserted in RUN.
- Reset timing: rst asserted at edge t gives all outputs at their reset values in cycle t+1, regardless of any handshake occurring at edge t.

## Test plan
- Basic nest: N=3, W=8, cfg_max={2,1,1} (levels 0,1,2) with m_ready=1 constantly.
  - Required: 12 beats in order (0,0,0),(1,0,0),(2,0,0),(0,1,0),…,(2,1,1).
  - m_last_all appears only on beat 12; done is high the following cycle; cfg_ready returns in that same cycle.
- Backpressure: same configuration with m_ready toggling pseudo-randomly.
  - Required: outputs are stable throughout every stall.
  - The accepted sequence is identical to the basic-nest run, and the accepted beat count is 12.
- Degenerate configurations:
  - cfg_max={0,0,0}: exactly 1 beat, with m_first=m_last=3'b111 and m_last_all=1.
  - cfg_max={255,0,0}: 256 beats, and level 0 reaches 255 without overflow.
- Reset mid-sequence: configure {3,3,3}, accept 5 beats, then assert rst for 1 cycle.
  - Required: next cycle m_valid=0, cfg_ready=1, m_count=0, done=0.
  - A fresh configuration {1,0,0} then yields exactly 2 beats.
- Back-to-back: hold cfg_valid=1 with {1,0,0} across two sequences.
  - Required: exactly one bubble cycle between the final beat of sequence 1 and the first tuple of sequence 2.
- Config ignored in RUN: change cfg_max mid-run.
  - Required: the sequence follows the latched values and cfg_ready stays 0 throughout RUN.
